// File: rtl/laser_pulse_checker_if.sv
// rtl/laser_pulse_checker_if.sv - laser pulse checker signal bundle
interface laser_pulse_checker_if;
  logic       xl;
  logic       valid;
  logic       err;
  logic       stuck;
  logic [7:0] last_len;
  logic [7:0] pulse_count;

  modport master (
    output xl,
    input  valid, err, stuck, last_len, pulse_count
  );

  modport slave (
    input  xl,
    output valid, err, stuck, last_len, pulse_count
  );
endinterface

// File: rtl/laser_pulse_checker.sv
// rtl/laser_pulse_checker.sv - measures laser ON pulse length, flags accepted/rejected/stuck pulses
module laser_pulse_checker #(
  parameter int unsigned PULSE_LEN = 16,
  parameter int unsigned TOL       = 0
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  laser_pulse_checker_if.slave  bus
);

  localparam int unsigned MAX_LEN  = 2 * PULSE_LEN;
  localparam logic [7:0]  MaxLen   = 8'(MAX_LEN);
  localparam logic [7:0]  PulseLen = 8'(PULSE_LEN);
  localparam logic [7:0]  Tol      = 8'(TOL);

  localparam logic [1:0] ARM   = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] STUCK = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] last_len_q, last_len_d;
  logic [7:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [7:0] dev;
  logic       accept;

  assign dev    = (len_q >= PulseLen) ? (len_q - PulseLen) : (PulseLen - len_q);
  assign accept = (dev <= Tol);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    last_len_d = last_len_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      // ARM waits for a low sample so a pulse in progress at reset release is ignored
      ARM: begin
        len_d = 8'd0;
        if (!bus.xl) state_d = IDLE;
      end
      IDLE: begin
        if (bus.xl) begin
          state_d = HIGH;
          len_d   = 8'd1;
        end
      end
      HIGH: begin
        if (bus.xl) begin
          len_d = len_q + 8'd1;
          if (len_q + 8'd1 == MaxLen) state_d = STUCK;
        end else begin
          state_d    = IDLE;
          len_d      = 8'd0;
          last_len_d = len_q;
          if (accept) begin
            valid_d = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STUCK: begin
        if (!bus.xl) begin
          state_d    = IDLE;
          len_d      = 8'd0;
          last_len_d = MaxLen;
          err_d      = 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= ARM;
      len_q      <= 8'd0;
      last_len_q <= 8'd0;
      count_q    <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      last_len_q <= last_len_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.valid       = valid_q;
  assign bus.err         = err_q;
  assign bus.stuck       = (state_q == STUCK);
  assign bus.last_len    = last_len_q;
  assign bus.pulse_count = count_q;

endmodule
